// File: rtl/pc_sequencer.sv
// Instruction sequencer: drives the external PC, fetches over a req/ack port and
// resolves JMP/JZ/CALL/RET/HALT locally, handing every other opcode to the datapath.
module pc_sequencer #(
    parameter int unsigned   AW        = 12,
    parameter int unsigned   IW        = 16,
    parameter int unsigned   DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] execadd,
    output logic          loadPC,
    output logic          incPC,
    output logic [AW-1:0] address,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    input  logic          zero_flag,
    output logic          exec_req,
    input  logic          exec_done,
    output logic [IW-1:0] instr,
    output logic          halted,
    output logic          fault
);

    localparam int unsigned SPW  = $clog2(DEPTH + 1);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BOOT   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_CALL = 4'h3;
    localparam logic [3:0] OP_RET  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic [AW-1:0]   stack_q [DEPTH];
    logic [SPW-1:0]  sp_m1;
    logic [PTRW-1:0] wr_idx, rd_idx;
    logic            push_en;
    logic [3:0]      opcode;
    logic [AW-1:0]   target;

    assign opcode    = instr_q[IW-1 -: 4];
    assign target    = instr_q[AW-1:0];
    assign sp_m1     = sp_q - SPW'(1);
    assign wr_idx    = sp_q[PTRW-1:0];
    assign rd_idx    = sp_m1[PTRW-1:0];
    assign imem_addr = execadd;
    assign instr     = instr_q;
    assign halted    = (state_q == S_HALTED) || (state_q == S_FAULT);
    assign fault     = (state_q == S_FAULT);

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        sp_d     = sp_q;
        push_en  = 1'b0;
        loadPC   = 1'b0;
        incPC    = 1'b0;
        address  = '0;
        imem_req = 1'b0;
        exec_req = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_BOOT;
            S_BOOT: begin
                loadPC  = 1'b1;
                address = RESET_VEC;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP: incPC = 1'b1;
                    OP_JMP: begin
                        loadPC  = 1'b1;
                        address = target;
                    end
                    OP_JZ: begin
                        if (zero_flag) begin
                            loadPC  = 1'b1;
                            address = target;
                        end else begin
                            incPC = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        if (sp_q == SPW'(DEPTH)) begin
                            state_d = S_FAULT;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SPW'(1);
                            loadPC  = 1'b1;
                            address = target;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            state_d = S_FAULT;
                        end else begin
                            sp_d    = sp_m1;
                            loadPC  = 1'b1;
                            address = stack_q[rd_idx];
                        end
                    end
                    OP_HALT: begin
                        incPC   = 1'b1;
                        state_d = S_HALTED;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                exec_req = 1'b1;
                if (exec_done) begin
                    incPC   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            // Resume continues after the HALT; the PC already moved past it.
            S_HALTED: if (start) state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            sp_q    <= sp_d;
        end
    end

    // Stack contents need no reset: the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[wr_idx] <= execadd + AW'(1);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural PC, memory and datapath responder
// surround the DUT; expected PC operations and fetch addresses are queued per program.
module tb_pc_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, zero_flag;
    logic [AW-1:0] execadd;
    logic          loadPC, incPC;
    logic [AW-1:0] address;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          exec_req, exec_done;
    logic [IW-1:0] instr;
    logic          halted, fault;

    always #5 clk = ~clk;

    pc_sequencer #(.AW(AW), .IW(IW), .DEPTH(4), .RESET_VEC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .execadd(execadd),
        .loadPC(loadPC), .incPC(incPC), .address(address),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .zero_flag(zero_flag),
        .exec_req(exec_req), .exec_done(exec_done), .instr(instr),
        .halted(halted), .fault(fault)
    );

    // Behavioural PC block; deliberately not reset.
    logic [AW-1:0] pc = '0;
    assign execadd = pc;
    always @(posedge clk) begin
        if (loadPC)     pc <= address;
        else if (incPC) pc <= pc + 12'd1;
    end

    logic [IW-1:0] mem [4096];
    int mem_wait = 0, exec_wait = 0, mcnt = 0, ecnt = 0;

    initial begin
        imem_ack = 1'b0; imem_data = '0; exec_done = 1'b0;
    end

    always @(negedge clk) begin
        if (imem_req) begin
            if (mcnt >= mem_wait) begin
                imem_ack = 1'b1; imem_data = mem[imem_addr]; mcnt = 0;
            end else begin
                imem_ack = 1'b0; mcnt++;
            end
        end else begin
            imem_ack = 1'b0; mcnt = 0;
        end
        if (exec_req) begin
            if (ecnt >= exec_wait) begin
                exec_done = 1'b1; ecnt = 0;
            end else begin
                exec_done = 1'b0; ecnt++;
            end
        end else begin
            exec_done = 1'b0; ecnt = 0;
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected PC operations are {load, inc, address}.
    logic [AW+1:0] exp_op [$];
    logic [AW-1:0] exp_fetch [$];

    task automatic exp_load(input logic [AW-1:0] a);
        exp_op.push_back({1'b1, 1'b0, a});
    endtask
    task automatic exp_inc();
        exp_op.push_back({1'b0, 1'b1, 12'h000});
    endtask
    task automatic exp_f(input logic [AW-1:0] a);
        exp_fetch.push_back(a);
    endtask

    int req_len = 0, exec_len = 0;
    logic [AW-1:0] hold_addr;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            req_len = 0; exec_len = 0;
        end else begin
            check("invariants", {28'd0, loadPC & incPC, imem_req & exec_req,
                  (!loadPC && address != '0), imem_addr != execadd}, 32'd0);
            if (loadPC || incPC) begin
                if (exp_op.size() == 0)
                    check("pcop_unexpected", {18'd0, loadPC, incPC, address}, 32'd0);
                else
                    check("pcop", {18'd0, loadPC, incPC, address}, {18'd0, exp_op.pop_front()});
            end
            if (imem_req) begin
                if (req_len > 0) check("imem_hold", {20'd0, imem_addr}, {20'd0, hold_addr});
                hold_addr = imem_addr;
                req_len++;
                if (imem_ack) begin
                    check("fetch_len", req_len, mem_wait + 1);
                    if (exp_fetch.size() == 0)
                        check("fetch_unexpected", {19'd0, 1'b1, imem_addr}, 32'd0);
                    else
                        check("fetch_addr", {20'd0, imem_addr}, {20'd0, exp_fetch.pop_front()});
                    req_len = 0;
                end
            end
            if (exec_req) begin
                exec_len++;
                if (exec_done) begin
                    check("exec_len", exec_len, exec_wait + 1);
                    exec_len = 0;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {loadPC, incPC, imem_req, exec_req, halted, fault, address, instr},
              34'd0);
    endtask

    task automatic run_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halt_timeout"}, {31'd0, halted}, 32'd1);
        #2 check({name, "_drained"}, exp_op.size() + exp_fetch.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; zero_flag = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        #1 check_idle_outputs("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        // Straight line, then resume from HALTED without reload.
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hF000; mem[3] = 16'hF000;
        exp_load(12'h000); exp_f(12'h000); exp_inc(); exp_f(12'h001); exp_inc();
        exp_f(12'h002); exp_inc();
        pulse_start();
        wait_halt("straight");
        check("straight_execadd", {20'd0, execadd}, 32'h003);
        check("straight_fault", {31'd0, fault}, 32'd0);
        exp_f(12'h003); exp_inc();
        pulse_start();
        wait_halt("resume");
        check("resume_execadd", {20'd0, execadd}, 32'h004);

        // JMP then JZ taken.
        run_reset(); clear_mem();
        mem[12'h000] = 16'h1123; mem[12'h123] = 16'h2200;
        zero_flag = 1'b1;
        exp_load(12'h000); exp_f(12'h000); exp_load(12'h123); exp_f(12'h123);
        exp_load(12'h200); exp_f(12'h200); exp_inc();
        pulse_start();
        wait_halt("jz_taken");
        check("jz_taken_execadd", {20'd0, execadd}, 32'h201);

        // JZ not taken.
        run_reset();
        zero_flag = 1'b0;
        exp_load(12'h000); exp_f(12'h000); exp_load(12'h123); exp_f(12'h123);
        exp_inc(); exp_f(12'h124); exp_inc();
        pulse_start();
        wait_halt("jz_not");
        check("jz_not_execadd", {20'd0, execadd}, 32'h125);

        // CALL / RET.
        run_reset(); clear_mem();
        mem[12'h000] = 16'h1010; mem[12'h010] = 16'h3300; mem[12'h300] = 16'h4000;
        exp_load(12'h000); exp_f(12'h000); exp_load(12'h010); exp_f(12'h010);
        exp_load(12'h300); exp_f(12'h300); exp_load(12'h011); exp_f(12'h011); exp_inc();
        pulse_start();
        wait_halt("callret");
        check("callret_execadd", {20'd0, execadd}, 32'h012);

        // Five nested CALLs: the fifth overflows the 4-deep stack.
        run_reset(); clear_mem();
        mem[12'h000] = 16'h3100; mem[12'h100] = 16'h3200; mem[12'h200] = 16'h3300;
        mem[12'h300] = 16'h3400; mem[12'h400] = 16'h3500;
        exp_load(12'h000); exp_f(12'h000); exp_load(12'h100); exp_f(12'h100);
        exp_load(12'h200); exp_f(12'h200); exp_load(12'h300); exp_f(12'h300);
        exp_load(12'h400); exp_f(12'h400);
        pulse_start();
        n = 0;
        while (!fault && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2 check("ovf_fault", {30'd0, fault, halted}, 32'd3);
        check("ovf_execadd", {20'd0, execadd}, 32'h400);
        pulse_start();
        repeat (10) @(negedge clk);
        #2 check("ovf_sticky", {30'd0, fault, halted}, 32'd3);
        check("ovf_execadd_after_start", {20'd0, execadd}, 32'h400);
        check("ovf_drained", exp_op.size() + exp_fetch.size(), 0);

        // Fetch stalls and a stretched EXEC.
        run_reset(); clear_mem();
        mem_wait = 3; exec_wait = 4;
        mem[12'h000] = 16'h5ABC;
        exp_load(12'h000); exp_f(12'h000); exp_inc(); exp_f(12'h001); exp_inc();
        pulse_start();
        wait_halt("stall");
        check("stall_execadd", {20'd0, execadd}, 32'h002);
        check("stall_instr", {16'd0, instr}, 32'hF000);
        mem_wait = 0; exec_wait = 0;

        // Wrap: CALL at 0xFFF must push 0x000.
        run_reset(); clear_mem();
        mem[12'h000] = 16'h1FFF; mem[12'hFFF] = 16'h3100; mem[12'h100] = 16'h4000;
        exp_load(12'h000); exp_f(12'h000); exp_load(12'hFFF); exp_f(12'hFFF);
        exp_load(12'h100); exp_f(12'h100); exp_load(12'h000); exp_f(12'h000); exp_inc();
        pulse_start();
        n = 0;
        while (execadd != 12'hFFF && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wrap_reach", {20'd0, execadd}, 32'hFFF);
        mem[12'h000] = 16'hF000;
        wait_halt("wrap");
        check("wrap_execadd", {20'd0, execadd}, 32'h001);

        // Asynchronous reset in the middle of EXEC, then a clean reboot.
        run_reset(); clear_mem();
        mem[12'h000] = 16'h5ABC; exec_wait = 1000;
        exp_load(12'h000); exp_f(12'h000);
        pulse_start();
        n = 0;
        while (!exec_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("midexec_req", {31'd0, exec_req}, 32'd1);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("midexec_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exec_wait = 0;
        mem[12'h000] = 16'hF000;
        exp_load(12'h000); exp_f(12'h000); exp_inc();
        pulse_start();
        wait_halt("reboot");
        check("reboot_execadd", {20'd0, execadd}, 32'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction sequencer that owns the 12-bit program counter (`PC` block). It pulses the counter's `loadPC`/`incPC` controls, fetches the instruction at `execadd` over a req/ack memory handshake, and resolves control-flow opcodes itself: JMP, JZ, CALL, RET and HALT, with CALL/RET using an internal return stack. All other opcodes go to the datapath through an exec handshake. It sits between the PC, instruction memory and the execute datapath.

## Interface
- `AW`, 12: address width; matches PC `address`/`execadd`.
- `IW`, 16: instruction width; opcode is `instr[IW-1:IW-4]`, target is `instr[AW-1:0]`.
- `DEPTH`, 4: return-stack entries.
- `RESET_VEC`, 12'h000: PC value loaded on boot.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; starts boot from IDLE, or resumes from HALTED.
- `execadd`  in  AW  current PC value from `PC`.
- `loadPC`  out  1  to PC: load `address` at the next edge.
- `incPC`  out  1  to PC: increment at the next edge.
- `address`  out  AW  to PC: load target.
- `imem_req`  out  1  fetch request, held until ack.
- `imem_addr`  out  AW  fetch address; always equals `execadd`.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_data`  in  IW  fetched instruction.
- `zero_flag`  in  1  ALU zero flag; used by JZ.
- `exec_req`  out  1  datapath op pending; held until done.
- `exec_done`  in  1  datapath op complete this cycle.
- `instr`  out  IW  latched current instruction.
- `halted`  out  1  high in HALTED state.
- `fault`  out  1  sticky stack-error flag.

## Operation
- Opcodes:
  - 0x0 NOP
  - 0x1 JMP
  - 0x2 JZ
  - 0x3 CALL
  - 0x4 RET
  - 0xF HALT
  - 0x5–0xE EXEC (datapath op)
- States: IDLE, BOOT, FETCH, DECODE, EXEC, HALTED, FAULT.
- IDLE: all outputs inactive. `start`=1 → BOOT.
- BOOT: drive `loadPC`=1 and `address`=RESET_VEC for one cycle → FETCH.
- FETCH: `imem_req`=1. On `imem_ack`=1, latch `imem_data` into `instr` → DECODE. With no ack, stay in FETCH with the request held.
- DECODE: acts once, in exactly one cycle:
  - NOP: `incPC` → FETCH.
  - JMP: `loadPC`, `address`=target → FETCH.
  - JZ: sample `zero_flag` this cycle. If 1, `loadPC` to target; if 0, `incPC`. Then → FETCH.
  - CALL: if stack not full, push (`execadd`+1) mod 2^AW, `loadPC` to target → FETCH. If full → FAULT with no PC change.
  - RET: if stack not empty, `loadPC` with `address`=top, pop → FETCH. If empty → FAULT with no PC change.
  - HALT: `incPC` → HALTED.
  - EXEC: → EXEC.
- EXEC: `exec_req`=1 until `exec_done`. In the `exec_done` cycle, assert `incPC` (Mealy) → FETCH.
- HALTED: `halted`=1. `start`=1 → FETCH, with no reload, so execution resumes after the HALT.
- FAULT: `fault`=1 and `halted`=1. `start` is ignored; only reset exits.
- `address` is 0 whenever `loadPC`=0.
- `loadPC` and `incPC` are never high together.

## Timing
- Reset (async, any state including mid-fetch or mid-exec):
  - state → IDLE; stack pointer → 0; `instr` → 0.
  - `loadPC`, `incPC`, `imem_req`, `exec_req`, `halted`, `fault` → 0; `address` → 0.
  - PC contents are not touched.
- The PC updates on the edge that ends the cycle in which `loadPC`/`incPC` is high. The following FETCH therefore presents the new `execadd`.
- Cycle counts, zero-wait memory:
  - NOP, JMP, JZ, CALL, RET: 2 cycles each (FETCH, DECODE).
  - EXEC op: 3 + N cycles, where N is the number of extra cycles before `exec_done`.
  - Each memory wait cycle adds 1.
- Boot: `start` seen in IDLE → BOOT next cycle → first `imem_req` the cycle after.
- `imem_req` and `exec_req` are never high together.
- Wrap-around:
  - `incPC` at 0xFFF is left to PC wrap (→ 0x000).
  - CALL at 0xFFF pushes 0x000.
- Stack:
  - A push at `DEPTH` entries faults.
  - A pop at 0 entries faults.
  - CALL with exactly `DEPTH`-1 entries succeeds.
- `imem_ack` or `exec_done` outside the matching state is ignored.

## Test plan
- Boot and straight line: reset, `start` pulse, memory 0x000=NOP, 0x001=NOP, 0x002=HALT, zero-wait. Required: `loadPC` one cycle with `address`=0x000; fetches at 0x000, 0x001, 0x002; `halted`=1; `execadd`=0x003.
- Jumps: 0x000=JMP 0x123, 0x123=JZ 0x200. With `zero_flag`=1 the next fetch is 0x200. Rerun with `zero_flag`=0: next fetch is 0x124.
- Call/return: 0x010=CALL 0x300, 0x300=RET. Required: fetch 0x300, then 0x011. Five nested CALLs: the fifth sets `fault`=1, `halted`=1, `execadd` unchanged; `start` has no effect afterwards.
- Handshake stalls:
  - `imem_ack` delayed 3 cycles: `imem_req` and `imem_addr` held steady.
  - EXEC op 0x5ABC with `exec_done` after 4 cycles: `exec_req` high 5 cycles, a single `incPC`.
- Wrap: PC=0xFFF holding CALL 0x100. Required: stack top 0x000; RET returns a fetch at 0x000.
- Reset mid-EXEC: drop `rst_n` while `exec_req`=1. Required: all outputs 0 immediately (async), IDLE; a later `start` reboots to RESET_VEC.
